// File: rtl/hack_ram_dp_clr_if.sv
// Port bundle for hack_ram_dp_clr: clear request/busy, write port and registered read port.
// The RAM takes the slave modport and the client takes the master modport.
interface hack_ram_dp_clr_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
);
    logic              clr_req;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/hack_ram_dp_clr.sv
// Simple-dual-port Hack data RAM with a registered read port and a built-in clear engine.
// Optional macro RAM_BYPASS_EN: same-address read and write in one cycle returns the new data.
module hack_ram_dp_clr #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    hack_ram_dp_clr_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StIdle  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              port_ok;

    // Client ports are live only in IDLE and only when no clear is being requested.
    assign port_ok = (state_q == StIdle) && !bus.clr_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Single physical write port shared by the clear engine and the client.
    always_comb begin
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else begin
            mem_we    = port_ok && bus.wr_en;
            mem_waddr = bus.wr_addr;
            mem_wdata = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef RAM_BYPASS_EN
    assign rd_word = (bus.wr_en && (bus.wr_addr == bus.rd_addr)) ? bus.wr_data
                                                                 : mem[bus.rd_addr];
`else
    assign rd_word = mem[bus.rd_addr];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= port_ok && bus.rd_en;
            if (port_ok && bus.rd_en) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign bus.busy     = (state_q == StClear);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_hack_ram_dp_clr.sv
// Self-checking bench for hack_ram_dp_clr: directed vector table plus clear/reset sequences.
module tb_hack_ram_dp_clr;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int DEPTH = 64;
`ifdef RAM_BYPASS_EN
    localparam logic [15:0] SameAddrData = 16'h2222;
`else
    localparam logic [15:0] SameAddrData = 16'h1111;
`endif

    typedef struct {
        logic        wr_en;
        logic [5:0]  wr_addr;
        logic [15:0] wr_data;
        logic        rd_en;
        logic [5:0]  rd_addr;
        logic        exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hack_ram_dp_clr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hack_ram_dp_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        bus.clr_req = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
    endtask

    task automatic do_write(input int addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'(addr);
        bus.wr_data = data;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_read(input int addr, input logic [15:0] exp, input string name);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 6'(addr);
        step();
        bus.rd_en = 1'b0;
        check($sformatf("%s_valid@%0d", name, addr), {31'd0, bus.rd_valid}, 32'd1);
        check($sformatf("%s_data@%0d", name, addr), {16'd0, bus.rd_data}, {16'd0, exp});
    endtask

    // Counts edges until busy drops; while waiting, also counts any rd_valid pulses.
    task automatic wait_busy_low(output int n, output int valid_seen);
        n = 0;
        valid_seen = 0;
        do begin
            step();
            n++;
            if (bus.rd_valid) valid_seen++;
        end while (bus.busy && n < 200);
        if (n >= 200) $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
    endtask

    initial begin
        vec_t vecs[10];
        int   n;
        int   vs;

        vecs[0] = '{1'b1, 6'd5,  16'hBEEF, 1'b0, 6'd0,  1'b0, 16'h0000};
        vecs[1] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd5,  1'b1, 16'hBEEF};
        vecs[2] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd4,  1'b1, 16'h0000};
        vecs[3] = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd4,  1'b0, 16'h0000};
        vecs[4] = '{1'b1, 6'd9,  16'h1111, 1'b0, 6'd0,  1'b0, 16'h0000};
        vecs[5] = '{1'b1, 6'd9,  16'h2222, 1'b1, 6'd9,  1'b1, SameAddrData};
        vecs[6] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd9,  1'b1, 16'h2222};
        vecs[7] = '{1'b1, 6'd10, 16'h3333, 1'b1, 6'd5,  1'b1, 16'hBEEF};
        vecs[8] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd10, 1'b1, 16'h3333};
        vecs[9] = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd10, 1'b0, 16'h3333};

        idle_ports();
        #2 rst = 1'b0;
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd1);
        check("reset_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("reset_data", {16'd0, bus.rd_data}, 32'd0);
        step();
        step();
        check("reset_hold_busy", {31'd0, bus.busy}, 32'd1);

        // Release between edges; busy must last exactly DEPTH edges.
        rst = 1'b1;
        wait_busy_low(n, vs);
        check("init_clear_cycles", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) do_read(a, 16'h0000, "init_zero");
        step();
        check("read_valid_drops", {31'd0, bus.rd_valid}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_addr = vecs[i].wr_addr;
            bus.wr_data = vecs[i].wr_data;
            bus.rd_en   = vecs[i].rd_en;
            bus.rd_addr = vecs[i].rd_addr;
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, bus.rd_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_data", i), {16'd0, bus.rd_data}, {16'd0, vecs[i].exp_data});
        end
        idle_ports();

        // Back-to-back reads: one result per cycle in address order.
        for (int a = 0; a < 8; a++) do_write(a, 16'hA000 + 16'(a));
        for (int a = 0; a < 8; a++) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = 6'(a);
            step();
            check($sformatf("b2b_valid%0d", a), {31'd0, bus.rd_valid}, 32'd1);
            check($sformatf("b2b_data%0d", a), {16'd0, bus.rd_data}, 32'hA000 + a);
        end
        bus.rd_en = 1'b0;
        step();
        check("b2b_valid_end", {31'd0, bus.rd_valid}, 32'd0);
        check("b2b_data_hold", {16'd0, bus.rd_data}, 32'hA007);

        // Clear request wins over a same-cycle write and read; ports ignored while busy.
        for (int a = 0; a < DEPTH; a++) do_write(a, 16'(a * 3));
        do_read(7, 16'd21, "prefill");
        bus.clr_req = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'd1;
        bus.wr_data = 16'hFFFF;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 6'd2;
        step();
        bus.clr_req = 1'b0;
        bus.wr_addr = 6'd3;
        bus.wr_data = 16'h5555;
        check("clr_busy", {31'd0, bus.busy}, 32'd1);
        check("clr_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("clr_rd_data_hold", {16'd0, bus.rd_data}, 32'd21);
        wait_busy_low(n, vs);
        idle_ports();
        check("clr_cycles", n, DEPTH);
        check("clr_valid_pulses", vs, 0);
        check("clr_data_hold_end", {16'd0, bus.rd_data}, 32'd21);
        for (int a = 0; a < DEPTH; a++) do_read(a, 16'h0000, "post_clr");

        // Reset 20 cycles into a clear: clear restarts from address 0.
        do_write(0, 16'h1234);
        do_write(63, 16'h4321);
        do_read(63, 16'h4321, "pre_abort");
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 20; i++) step();
        do_write(0, 16'h7777);
        rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd1);
        check("abort_data", {16'd0, bus.rd_data}, 32'd0);
        step();
        rst = 1'b1;
        wait_busy_low(n, vs);
        check("abort_clear_cycles", n, DEPTH);
        do_read(0, 16'h0000, "abort_zero");
        do_read(63, 16'h0000, "abort_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish before 400000");
        $fatal(1);
    end
endmodule
